// File: rtl/initial_try_10_pkg.sv
// Shared constants for the initial_try_10 UART loopback buffer: bit timing and FSM state codes.
package initial_try_10_pkg;

    localparam int CLKS_PER_BIT = 1250;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2 - 1;
    localparam int CNT_W        = 11;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_START = 2'd1;
    localparam logic [1:0] TX_DATA  = 2'd2;
    localparam logic [1:0] TX_STOP  = 2'd3;

endpackage

// File: rtl/uart_rx_8n1.sv
// 8N1 receiver: 2-flop synchronizer, mid-bit sampling, one-cycle valid per byte.
// Optional RX_FRAME_CHECK_EN drops frames whose stop bit samples low.
module uart_rx_8n1
    import initial_try_10_pkg::*;
#(
    parameter int CLKS = CLKS_PER_BIT,
    parameter int HALF = HALF_BIT
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       rx,
    input  logic       hold,
    output logic [7:0] data,
    output logic       valid
);

    localparam logic [CNT_W-1:0] HALF_C = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(CLKS - 1);

    logic             rx_meta;
    logic             rx_sync;
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
`ifdef RX_FRAME_CHECK_EN
    logic             wait_high;
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            state     <= RX_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            data      <= '0;
            valid     <= 1'b0;
`ifdef RX_FRAME_CHECK_EN
            wait_high <= 1'b0;
`endif
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            valid   <= 1'b0;
            case (state)
                RX_IDLE: begin
                    cnt <= '0;
                    if (!hold && !rx_sync)
                        state <= RX_START;
                end
                // A start bit that is high again at its centre was a glitch.
                RX_START: begin
                    if (cnt == HALF_C) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == LAST_C) begin
                        cnt   <= '0;
                        shreg <= {rx_sync, shreg[7:1]};
                        if (bit_idx == 3'd7)
                            state <= RX_STOP;
                        else
                            bit_idx <= bit_idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
`ifdef RX_FRAME_CHECK_EN
                    if (wait_high) begin
                        if (rx_sync) begin
                            wait_high <= 1'b0;
                            state     <= RX_IDLE;
                        end
                    end else if (cnt == LAST_C) begin
                        cnt <= '0;
                        if (rx_sync) begin
                            data  <= shreg;
                            valid <= 1'b1;
                            state <= RX_IDLE;
                        end else begin
                            wait_high <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`else
                    if (cnt == LAST_C) begin
                        cnt   <= '0;
                        data  <= shreg;
                        valid <= 1'b1;
                        state <= RX_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
            endcase
        end
    end

endmodule

// File: rtl/initial_try_10.sv
// UART loopback buffer: collects WORD_BYTES 8N1 bytes, then retransmits them in order while busy.
// Build option RX_FRAME_CHECK_EN (in uart_rx_8n1) discards frames with a bad stop bit.
module initial_try_10
    import initial_try_10_pkg::*;
#(
    parameter int CLK_HZ     = 12_000_000,
    parameter int BAUD       = 9600,
    parameter int WORD_BYTES = 4
) (
    input  logic clk,
    input  logic nrst,
    input  logic rx,
    output logic tx,
    output logic busy
);

    localparam int BIT_CLKS = CLK_HZ / BAUD;
    localparam int HALF     = BIT_CLKS / 2 - 1;
    localparam int IDX_W    = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(BIT_CLKS - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);

    logic [7:0]              rx_data;
    logic                    rx_valid;
    logic [8*WORD_BYTES-1:0] buffer;
    logic [IDX_W-1:0]        byte_cnt;
    logic [1:0]              tx_state;
    logic [CNT_W-1:0]        tx_cnt;
    logic [2:0]              tx_bit;
    logic [IDX_W-1:0]        tx_byte;
    logic [7:0]              cur_byte;

    uart_rx_8n1 #(
        .CLKS (BIT_CLKS),
        .HALF (HALF)
    ) u_rx (
        .clk   (clk),
        .nrst  (nrst),
        .rx    (rx),
        .hold  (busy),
        .data  (rx_data),
        .valid (rx_valid)
    );

    assign cur_byte = buffer[{tx_byte, 3'b000} +: 8];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            tx       <= 1'b1;
            busy     <= 1'b0;
            buffer   <= '0;
            byte_cnt <= '0;
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_byte  <= '0;
        end else begin
            // The start bit goes out on the same edge that busy rises.
            if (rx_valid && !busy) begin
                buffer[{byte_cnt, 3'b000} +: 8] <= rx_data;
                if (byte_cnt == LAST_IDX) begin
                    byte_cnt <= '0;
                    busy     <= 1'b1;
                    tx_state <= TX_START;
                    tx       <= 1'b0;
                    tx_cnt   <= '0;
                    tx_byte  <= '0;
                end else begin
                    byte_cnt <= byte_cnt + 1'b1;
                end
            end
            case (tx_state)
                TX_START: begin
                    if (tx_cnt == LAST_C) begin
                        tx_cnt   <= '0;
                        tx_bit   <= '0;
                        tx       <= cur_byte[0];
                        tx_state <= TX_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt == LAST_C) begin
                        tx_cnt <= '0;
                        if (tx_bit == 3'd7) begin
                            tx       <= 1'b1;
                            tx_state <= TX_STOP;
                        end else begin
                            tx_bit <= tx_bit + 1'b1;
                            tx     <= cur_byte[tx_bit + 3'd1];
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (tx_cnt == LAST_C) begin
                        tx_cnt <= '0;
                        if (tx_byte == LAST_IDX) begin
                            busy     <= 1'b0;
                            tx_state <= TX_IDLE;
                        end else begin
                            tx_byte  <= tx_byte + 1'b1;
                            tx       <= 1'b0;
                            tx_state <= TX_START;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: begin
                    tx_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_initial_try_10.sv
// Scoreboard bench for initial_try_10: stimulus pushes expected echo bytes, monitors decode tx and busy.
module tb_initial_try_10;

    localparam int CPB = 16;

    logic clk;
    logic nrst;
    logic rx;
    logic tx;
    logic busy;

    int checks;
    int failures;
    logic [7:0] sb_q[$];

    initial_try_10 #(
        .CLK_HZ     (12_000_000),
        .BAUD       (750_000),
        .WORD_BYTES (4)
    ) dut (
        .clk  (clk),
        .nrst (nrst),
        .rx   (rx),
        .tx   (tx),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send_byte(input logic [7:0] b, input logic stop_val, input bit echo, input int gap_bits);
        if (echo) sb_q.push_back(b);
        @(posedge clk);
        rx = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(posedge clk);
        end
        rx = stop_val;
        repeat (CPB) @(posedge clk);
        rx = 1'b1;
        repeat (gap_bits * CPB) @(posedge clk);
    endtask

    task automatic wait_done(input string name);
        int n;
        for (n = 0; n < 4000; n++) begin
            @(negedge clk);
            if (!busy && sb_q.size() == 0) break;
        end
        checks++;
        if (n >= 4000) begin
            failures++;
            $display("FAIL %s timeout busy=%0b pending=%0d required busy=0 pending=0", name, busy, sb_q.size());
        end
    endtask

    task automatic wait_busy(input string name);
        int n;
        for (n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (busy) break;
        end
        checks++;
        if (n >= 2000) begin
            failures++;
            $display("FAIL %s busy never rose, got=0 required=1", name);
        end
    endtask

    task automatic quiet(input int cycles, input string name);
        bit bad;
        bad = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL %s activity seen tx=%0b busy=%0b required tx=1 busy=0", name, tx, busy);
        end
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (tx !== 1'b1) begin
            failures++;
            $display("FAIL %s_tx got=%0b required=1", name, tx);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_busy got=%0b required=0", name, busy);
        end
    endtask

    // tx decoder: samples each bit centre and pops the expected byte
    initial begin : tx_mon
        logic [7:0] got;
        logic [7:0] expv;
        logic       stop_s;
        bit         aborted;
        forever begin
            @(negedge clk);
            if (nrst === 1'b1 && tx === 1'b0) begin
                aborted = 1'b0;
                got     = '0;
                stop_s  = 1'b0;
                for (int k = 1; k <= 9 * CPB + CPB / 2; k++) begin
                    @(negedge clk);
                    if (nrst !== 1'b1) aborted = 1'b1;
                    if (k >= CPB + CPB / 2 && ((k - CPB - CPB / 2) % CPB) == 0) begin
                        if (k == 9 * CPB + CPB / 2) stop_s = tx;
                        else got[(k - CPB - CPB / 2) / CPB] = tx;
                    end
                end
                if (!aborted) begin
                    checks++;
                    if (sb_q.size() == 0) begin
                        failures++;
                        $display("FAIL tx_byte unexpected got=%h required=none", got);
                    end else begin
                        expv = sb_q.pop_front();
                        if (got !== expv) begin
                            failures++;
                            $display("FAIL tx_byte got=%h required=%h", got, expv);
                        end
                    end
                    checks++;
                    if (stop_s !== 1'b1) begin
                        failures++;
                        $display("FAIL tx_stop got=%0b required=1", stop_s);
                    end
                end
            end
        end
    end

    // busy must coincide with the first start bit and last exactly 40 bit times
    initial begin : busy_mon
        int len;
        bit counting;
        len      = 0;
        counting = 1'b0;
        forever begin
            @(negedge clk);
            if (nrst !== 1'b1) begin
                counting = 1'b0;
            end else if (busy === 1'b1 && !counting) begin
                counting = 1'b1;
                len      = 1;
                checks++;
                if (tx !== 1'b0) begin
                    failures++;
                    $display("FAIL busy_start_tx got=%0b required=0", tx);
                end
            end else if (busy === 1'b1) begin
                len++;
            end else if (counting) begin
                counting = 1'b0;
                checks++;
                if (len != 40 * CPB) begin
                    failures++;
                    $display("FAIL busy_len got=%0d required=%0d", len, 40 * CPB);
                end
            end
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        rx       = 1'b1;
        nrst     = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        nrst = 1'b1;
        quiet(5 * CPB, "idle_after_reset");
        check_idle("idle");

        send_byte(8'h53, 1'b1, 1'b1, 10);
        send_byte(8'h6E, 1'b1, 1'b1, 10);
        send_byte(8'h61, 1'b1, 1'b1, 10);
        send_byte(8'h70, 1'b1, 1'b1, 10);
        wait_done("burst1");

        send_byte(8'h11, 1'b1, 1'b1, 2);
        send_byte(8'h22, 1'b1, 1'b1, 2);
        send_byte(8'h33, 1'b1, 1'b1, 2);
        quiet(20 * CPB, "three_bytes_hold");
        send_byte(8'hFF, 1'b1, 1'b1, 0);
        wait_done("fourth_ff");

        send_byte(8'h01, 1'b1, 1'b1, 1);
        send_byte(8'h02, 1'b1, 1'b1, 1);
        send_byte(8'h03, 1'b1, 1'b1, 1);
        send_byte(8'h04, 1'b1, 1'b1, 0);
        wait_busy("busy_rise");
        send_byte(8'hA5, 1'b1, 1'b0, 2);
        wait_done("drop_a5");
        send_byte(8'hC3, 1'b1, 1'b1, 1);
        send_byte(8'h3C, 1'b1, 1'b1, 1);
        send_byte(8'h00, 1'b1, 1'b1, 1);
        send_byte(8'h80, 1'b1, 1'b1, 0);
        wait_done("after_drop");

        @(posedge clk);
        rx = 1'b0;
        repeat (4) @(posedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(posedge clk);
        send_byte(8'hDE, 1'b1, 1'b1, 1);
        send_byte(8'hAD, 1'b1, 1'b1, 1);
        send_byte(8'hBE, 1'b1, 1'b1, 1);
        send_byte(8'hEF, 1'b1, 1'b1, 0);
        wait_done("after_glitch");

        send_byte(8'h12, 1'b1, 1'b1, 1);
        send_byte(8'h34, 1'b1, 1'b1, 1);
        send_byte(8'h56, 1'b1, 1'b1, 1);
        send_byte(8'h78, 1'b1, 1'b1, 0);
        wait_busy("busy_rise2");
        repeat (200) @(negedge clk);
        nrst = 1'b0;
        sb_q.delete();
        #1;
        check_idle("mid_reset");
        @(negedge clk);
        nrst = 1'b1;
        quiet(4 * CPB, "post_reset_quiet");
`ifdef RX_FRAME_CHECK_EN
        send_byte(8'h77, 1'b0, 1'b0, 2);
`endif
        send_byte(8'h9A, 1'b1, 1'b1, 1);
        send_byte(8'hBC, 1'b1, 1'b1, 1);
        send_byte(8'hDE, 1'b1, 1'b1, 1);
        send_byte(8'hF0, 1'b1, 1'b1, 0);
        wait_done("after_reset");
        repeat (CPB) @(negedge clk);
        check_idle("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/initial_try_10.md
# initial_try_10

UART loopback buffer for a 12 MHz board: receives 8N1 bytes at 9600 baud on `rx`, collects four of them into a 32-bit buffer, then retransmits all four on `tx` in arrival order. `busy` flags the retransmit phase, during which new input is ignored. It sits between the board's serial pin pair and nothing else; it is self-contained.

## Interface
- `CLK_HZ`, 12_000_000, system clock frequency.
- `BAUD`, 9600, line rate; `CLKS_PER_BIT = CLK_HZ/BAUD` (1250 by default).
- `WORD_BYTES`, 4, bytes collected before retransmit.
- `clk`  in  1  system clock, rising-edge.
- `nrst`  in  1  reset; one clock, reset is asynchronous and active-low.
- `rx`  in  1  serial input, idle high, asynchronous to `clk`.
- `tx`  out  1  serial output, idle high.
- `busy`  out  1  high while the buffered word is being retransmitted.

## Operation
- Reset: `tx`=1, `busy`=0, buffer=0, byte count=0, all bit/clock counters=0, RX and TX FSMs in IDLE.
- `rx` passes a 2-flop synchronizer; all RX decisions use the synchronized value.
- RX FSM: IDLE → START on synchronized `rx`=0. START: at half-bit (count 624) re-sample; 0 → DATA, 1 → IDLE (glitch rejected). DATA: sample every `CLKS_PER_BIT` clocks at bit centre, LSB first, 8 bits. STOP: sample at stop-bit centre, then byte is stored, RX → IDLE.
- Byte *k* (0..3) is stored at buffer bits [8k+7:8k]; byte count increments, 2-bit wrap.
- When the 4th byte is stored: byte count → 0, `busy` → 1, TX starts.
- TX FSM: IDLE → START (`tx`=0) → DATA ×8 (LSB first) → STOP (`tx`=1) per byte; byte 0 first, frames back-to-back, each state lasts exactly `CLKS_PER_BIT` clocks.
- After the 4th stop bit completes: `busy` → 0, TX → IDLE.
- While `busy`=1 the RX FSM is held in IDLE; bytes arriving then are dropped. Partial bytes in progress when `busy` rises cannot occur (busy rises only at RX IDLE).
- Fewer than 4 received bytes: nothing transmitted, bytes held indefinitely.

## Timing
- Clock counter 11 bits, counts 0..`CLKS_PER_BIT`-1 then wraps.
- Start-edge detect latency: 2 clocks (synchronizer).
- `busy` rises 1 clock after the 4th stop-bit sample; first `tx` start bit drives the same cycle `busy` rises.
- Retransmit length: 40 bit times = 50 000 clocks; `busy` is high for exactly that.
- Idle gap between received bytes: unbounded.
- `nrst` low mid-frame or mid-retransmit: immediately `tx`=1, `busy`=0, buffer and count cleared.

## Configuration
- `RX_FRAME_CHECK_EN` defined: a byte whose stop-bit sample is 0 is discarded (not stored, count unchanged), RX waits for `rx`=1 before returning to IDLE.
- Not defined: stop-bit value ignored; every completed frame is stored.

## Structure
- Package `initial_try_10_pkg`: `CLKS_PER_BIT`, `HALF_BIT`, RX and TX state enums (IDLE, START, DATA, STOP).
- One sub-module `uart_rx_8n1` (synchronizer, RX FSM, outputs byte + 1-cycle valid); TX FSM and buffer stay in the top.

## Test plan
- Reset: `nrst`=0 → `tx`=1, `busy`=0; release, 5 idle bit times → outputs unchanged.
- Send 0x53, 0x6E, 0x61, 0x70 with 10-bit-time gaps → `busy` high 50 000 clocks, `tx` emits 0x53, 0x6E, 0x61, 0x70 8N1, then `busy`=0.
- Send 3 bytes only → `tx` stays 1, `busy` stays 0; 4th byte 0xFF → all four retransmitted.
- Send 0xA5 while `busy`=1 → ignored; next four bytes after `busy` falls are echoed exactly.
- `rx` low pulse of 300 clocks → no byte counted.
- Assert `nrst` mid-retransmit → `tx`=1, `busy`=0 next edge; subsequent 4-byte burst echoed correctly (with `RX_FRAME_CHECK_EN`, a frame with stop=0 is not counted).
